keypad_key_fifo: RTL
====================

Name: keypad_key_fifo

Overview:
- Downstream consumer of the keypad scanner's 8-bit KeypadData word.
- Debounces the key-down indication and turns each distinct physical press into exactly one 4-bit key event.
- Buffers events in a small FIFO and hands them to the CPU-side I/O logic over a valid/ready handshake.
- Runs on the same divided scan clock (1 kHz) as the scanner.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical samples required to accept a press or a release (legal range 1..255).
- FIFO_DEPTH, 4: number of buffered key events; must be a power of two, 2..16.

Ports:
- Clock  input  1  scan-domain clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high; clears all state.
- KeypadData  input  8  scanner output: [7] = key-down flag, [6:4] ignored, [3:0] = hex key code (0-F).
- KeyValid  output  1  FIFO head holds an unread event.
- KeyCode  output  4  FIFO head code; valid only while KeyValid=1.
- KeyReady  input  1  consumer accepts head when KeyValid & KeyReady at a rising edge.
- FifoCount  output  $clog2(FIFO_DEPTH+1)  number of stored events.
- Overflow  output  1  sticky; a press was dropped because the FIFO was full.
- ClearOverflow  input  1  synchronous clear of Overflow.
- DisplayValue  output  16  last four accepted codes (see Optional Feature).

Behaviour:
- Reset values: KeyValid=0, KeyCode=0, FifoCount=0, Overflow=0, DisplayValue=0. FSM=IDLE, debounce counter=0. Reset dominates every other input.
- Sample register: KeypadData is registered once (SampleReg) before the FSM. All comparisons use SampleReg.
- FSM states and transitions:
  - IDLE: SampleReg[7]=1 -> PRESS_WAIT, capture CandCode=SampleReg[3:0], cnt=1.
  - PRESS_WAIT:
    - SampleReg[7]=0 -> IDLE.
    - Code differs from CandCode -> stay, CandCode=new code, cnt=1.
    - Same code -> cnt+1.
    - When cnt reaches DEBOUNCE_CYCLES: generate a push of CandCode and go to HELD.
    - With DEBOUNCE_CYCLES=1 the push happens on the IDLE->PRESS_WAIT edge's next cycle.
  - HELD: SampleReg[7]=0 -> RELEASE_WAIT, cnt=1. Code changes while held are ignored; no auto-repeat.
  - RELEASE_WAIT:
    - SampleReg[7]=1 -> HELD.
    - Otherwise cnt+1; at DEBOUNCE_CYCLES -> IDLE.
- Press latency: KeypadData stable from edge k gives a push at edge k+DEBOUNCE_CYCLES. KeyValid rises the cycle after the push if the FIFO was empty.
- FIFO:
  - Circular buffer with registered read/write pointers of width log2(FIFO_DEPTH), wrapping naturally.
  - Occupancy counter drives FifoCount.
  - KeyCode is driven from storage[rd_ptr]. KeyValid = (FifoCount != 0).
- Boundary conditions:
  - Pop and push in the same cycle: both occur, FifoCount unchanged. This holds when full, because the pop frees a slot in that cycle, so no overflow is raised.
  - Push when full with no pop: the event is dropped and Overflow is set to 1.
  - Pop when empty: ignored.
  - ClearOverflow together with a new overflow in the same cycle: set wins.
  - Reset mid-debounce or while HELD: the FSM returns to IDLE. A key still held after reset counts as a new press once debounced.

Optional Feature:
- Macro KEYPAD_DISPLAY_ACCUM_EN.
- Defined: every accepted push (not dropped ones) updates DisplayValue <= {DisplayValue[11:0], code}, giving a 4-digit hex entry register for the seven-segment display.
- Not defined: DisplayValue is tied to 16'h0000 and no accumulator flops are built.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - KD_FLAG_BIT=7;
  - KD_CODE_MSB=3 / KD_CODE_LSB=0.
- One sub-module is natural: key_event_fifo (parameterised FIFO_DEPTH × 4-bit, push/pop/count/full), instantiated once. The debounce FSM stays in the top.

Test Plan:
- Clean press: KeypadData=8'h85 held 10 cycles, then 8'h00. Expect exactly one event with KeyCode=5; KeyValid rises 5 cycles after the first 8'h85 edge; FifoCount=1.
- Bounce: 8'h83, 8'h00, 8'h83, 8'h83, 8'h00 repeated. Expect no event. Then hold 8'h83 for 4 stable cycles: one event, code 3.
- Code change mid-debounce: 8'h81 ×2 then 8'h82 ×4. Expect a single event with code 2.
- Overflow: KeyReady=0, five debounced presses with codes 1,2,3,4,5. Expect FifoCount=4 and Overflow=1. Then popping returns 1,2,3,4 in order. ClearOverflow drops Overflow to 0.
- Full plus simultaneous pop: FIFO full, KeyReady=1 on the same edge as a push of code 9. Expect FifoCount stays 4, Overflow stays 0, and 9 is read last.
- Reset while HELD with 8'h8A still applied: FifoCount=0 and KeyValid=0 after reset. A new event with code A appears after the debounce period. With KEYPAD_DISPLAY_ACCUM_EN, presses 1,2,3,4 give DisplayValue=16'h1234.

Source files
------------

// File: rtl/keypad_key_fifo_pkg.sv
// Shared types and field positions for the keypad key-event path.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } kp_state_e;

   localparam int KD_FLAG_BIT = 7;
   localparam int KD_CODE_MSB = 3;
   localparam int KD_CODE_LSB = 0;

endpackage

// File: rtl/keypad_key_fifo_event_fifo.sv
// Circular buffer of 4-bit key events; a pop in the same cycle frees a slot for a push.
module key_event_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              push_i,
   input  logic [3:0]                        push_data_i,
   input  logic                              pop_i,
   output logic [3:0]                        head_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
   output logic                              full_o,
   output logic                              push_accepted_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_pop;
   logic          do_push;

   assign full_o  = (count_q == CW'(FIFO_DEPTH));
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (!full_o || do_pop);

   assign head_o          = mem_q[rd_ptr_q];
   assign count_o         = count_q;
   assign push_accepted_o = do_push;

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 4'h0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/keypad_key_fifo.sv
// Debounces scanner key-down words into single key events and queues them for the CPU.
// Optional KEYPAD_DISPLAY_ACCUM_EN builds a 4-digit shift register of accepted codes.
module keypad_key_fifo
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                              Clock,
   input  logic                              Reset,
   input  logic [7:0]                        KeypadData,
   output logic                              KeyValid,
   output logic [3:0]                        KeyCode,
   input  logic                              KeyReady,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   FifoCount,
   output logic                              Overflow,
   input  logic                              ClearOverflow,
   output logic [15:0]                       DisplayValue
);

   localparam logic [8:0] DB = 9'(DEBOUNCE_CYCLES);

   logic [7:0] sample_q;
   kp_state_e  state_q;
   logic [3:0] cand_q;
   logic [7:0] cnt_q;
   logic       push_q;
   logic       overflow_q;
   logic       flag;
   logic [3:0] code;
   logic [8:0] cnt_inc;
   logic       push_accepted;
   logic       fifo_full;
   logic       unused_sample_bits;

   assign flag               = sample_q[KD_FLAG_BIT];
   assign code               = sample_q[KD_CODE_MSB:KD_CODE_LSB];
   assign cnt_inc            = {1'b0, cnt_q} + 9'd1;
   assign unused_sample_bits = ^{sample_q[6:4], fifo_full};

   // push_q is a registered strobe: the FIFO write lands one edge after the count completes.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         sample_q <= 8'h00;
         state_q  <= IDLE;
         cand_q   <= 4'h0;
         cnt_q    <= 8'd0;
         push_q   <= 1'b0;
      end else begin
         sample_q <= KeypadData;
         push_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flag) begin
                  state_q <= PRESS_WAIT;
                  cand_q  <= code;
                  cnt_q   <= 8'd1;
               end
            end
            PRESS_WAIT: begin
               if (!flag) begin
                  state_q <= IDLE;
               end else if (code != cand_q) begin
                  cand_q <= code;
                  cnt_q  <= 8'd1;
               end else if (cnt_inc >= DB) begin
                  push_q  <= 1'b1;
                  state_q <= HELD;
               end else begin
                  cnt_q <= cnt_inc[7:0];
               end
            end
            HELD: begin
               if (!flag) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= 8'd1;
               end
            end
            RELEASE_WAIT: begin
               if (flag) begin
                  state_q <= HELD;
               end else if (cnt_inc >= DB) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_inc[7:0];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   key_event_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i           (Clock),
      .rst_i           (Reset),
      .push_i          (push_q),
      .push_data_i     (cand_q),
      .pop_i           (KeyReady),
      .head_o          (KeyCode),
      .count_o         (FifoCount),
      .full_o          (fifo_full),
      .push_accepted_o (push_accepted)
   );

   assign KeyValid = (FifoCount != '0);

   // A new drop outranks a clear arriving in the same cycle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         overflow_q <= 1'b0;
      end else if (push_q && !push_accepted) begin
         overflow_q <= 1'b1;
      end else if (ClearOverflow) begin
         overflow_q <= 1'b0;
      end
   end

   assign Overflow = overflow_q;

`ifdef KEYPAD_DISPLAY_ACCUM_EN
   logic [15:0] disp_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         disp_q <= 16'h0000;
      end else if (push_accepted) begin
         disp_q <= {disp_q[11:0], cand_q};
      end
   end

   assign DisplayValue = disp_q;
`else
   assign DisplayValue = 16'h0000;
`endif

endmodule
